// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the wait-stated data-memory responder.
package data_mem_responder_pkg;

    localparam int unsigned WORD_W = 16;

    localparam logic ERR_NONE  = 1'b0;
    localparam logic ERR_FAULT = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // Misaligned byte address, or word index beyond the array (upper bits must be zero).
    function automatic logic addr_fault(input logic [WORD_W-1:0] addr,
                                        input int unsigned      depth_words);
        logic [31:0] idx;
        idx = 32'(addr[WORD_W-1:1]);
        return addr[0] | (idx >= depth_words);
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Load/store request-response bus between the core and the data-memory responder.
interface data_mem_responder_if;
    import data_mem_responder_pkg::*;

    logic              req;
    logic              we;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
    logic              accept;
    logic              ack;
    logic [WORD_W-1:0] rdata;
    logic              err;
    logic              busy;

    modport master (
        output req, we, addr, wdata,
        input  accept, ack, rdata, err, busy
    );

    modport slave (
        input  req, we, addr, wdata,
        output accept, ack, rdata, err, busy
    );

endinterface

// File: rtl/data_mem_responder_wait_counter.sv
// Loadable down-counter with zero flag; shared by data and fetch wait-state logic.
module data_mem_responder_wait_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic             zero
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_value;
        end else if (dec && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign count = count_q;
    assign zero  = (count_q == '0);

endmodule

// File: rtl/data_mem_responder.sv
// Wait-stated data-memory target: one outstanding load/store, committed on entry to RESP.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    data_mem_responder_if.slave  bus
);

    localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);
    localparam bit          NO_WAIT   = (WAIT_CYCLES == 0);
    localparam logic [3:0]  WAIT_LOAD = NO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

    logic [WORD_W-1:0] mem [DEPTH_WORDS];

    state_e            state_q, state_d;
    logic              we_q;
    logic [WORD_W-1:0] addr_q, wdata_q, rdata_q;
    logic              err_q;

    logic              take, commit, accept, ack, busy;
    logic              cnt_load, cnt_dec, cnt_zero;
    logic [3:0]        cnt_value;
    logic              op_we, fault;
    logic [WORD_W-1:0] op_addr, op_wdata;
    logic [IDX_W-1:0]  idx;

    data_mem_responder_wait_counter #(
        .WIDTH (4)
    ) u_wait_counter (
        .clk        (clk),
        .reset      (reset),
        .load       (cnt_load),
        .load_value (WAIT_LOAD),
        .dec        (cnt_dec),
        .count      (cnt_value),
        .zero       (cnt_zero)
    );

    always_comb begin
        state_d  = state_q;
        take     = 1'b0;
        commit   = 1'b0;
        accept   = 1'b0;
        ack      = 1'b0;
        busy     = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        unique case (state_q)
            IDLE: begin
                accept = 1'b1;
                take   = bus.req;
            end
            WAIT: begin
                busy = 1'b1;
                if (cnt_zero) begin
                    state_d = RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            RESP: begin
                accept = 1'b1;
                ack    = 1'b1;
                take   = bus.req;
                if (!bus.req) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (take) begin
            if (NO_WAIT) begin
                state_d = RESP;
                commit  = 1'b1;
            end else begin
                state_d  = WAIT;
                cnt_load = 1'b1;
            end
        end
    end

    // Zero-wait commits on the acceptance edge, so the operation comes straight off the bus.
    always_comb begin
        op_we    = take ? bus.we    : we_q;
        op_addr  = take ? bus.addr  : addr_q;
        op_wdata = take ? bus.wdata : wdata_q;
        fault    = addr_fault(op_addr, DEPTH_WORDS);
        idx      = op_addr[IDX_W:1];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= ERR_NONE;
        end else begin
            state_q <= state_d;
            if (take) begin
                we_q    <= bus.we;
                addr_q  <= bus.addr;
                wdata_q <= bus.wdata;
            end
            if (commit) begin
                err_q   <= fault ? ERR_FAULT : ERR_NONE;
                rdata_q <= (op_we || fault) ? '0 : mem[idx];
            end
        end
    end

    // Array is not reset; gating on reset keeps a request seen under reset from writing.
    always_ff @(posedge clk) begin
        if (reset && commit && op_we && !fault) begin
            mem[idx] <= op_wdata;
        end
    end

    assign bus.accept = accept;
    assign bus.ack    = ack;
    assign bus.busy   = busy;
    assign bus.rdata  = rdata_q;
    assign bus.err    = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomised scoreboard bench for data_mem_responder (2-wait and zero-wait instances).
module tb_data_mem_responder;
    import data_mem_responder_pkg::*;

    localparam int unsigned D2 = 256;
    localparam int unsigned W2 = 2;
    localparam int unsigned D0 = 16;
    localparam int unsigned W0 = 0;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    data_mem_responder_if bus2 ();
    data_mem_responder_if bus0 ();

    data_mem_responder #(.DEPTH_WORDS(D2), .WAIT_CYCLES(W2)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    data_mem_responder #(.DEPTH_WORDS(D0), .WAIT_CYCLES(W0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    typedef struct {
        logic [15:0] rdata;
        logic        err;
        int          acc_cyc;
    } exp_t;

    exp_t        q2[$];
    exp_t        q0[$];
    exp_t        e2, e0;
    logic [15:0] m2 [D2];
    logic [15:0] m0 [D0];
    logic [15:0] last2_r, last0_r;
    logic        last2_e, last0_e;
    int          vectors     = 0;
    int          miscompares = 0;
    int          cyc         = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: memory effect and response computed at acceptance time.
    task automatic issue(input bit u, input logic w, input logic [15:0] a, input logic [15:0] d);
        int unsigned idx;
        int unsigned depth;
        bit          bad;
        bit          acc;
        exp_t        e;
        idx     = int'(a >> 1);
        depth   = u ? D0 : D2;
        bad     = a[0] || (idx >= depth);
        e.err   = bad;
        e.rdata = 16'h0000;
        if (u) begin
            bus0.req = 1'b1; bus0.we = w; bus0.addr = a; bus0.wdata = d;
        end else begin
            bus2.req = 1'b1; bus2.we = w; bus2.addr = a; bus2.wdata = d;
        end
        acc = 1'b0;
        for (int n = 0; n < 50 && !acc; n++) begin
            @(negedge clk);
            acc = u ? bus0.accept : bus2.accept;
        end
        check(u ? "dut0 accept timeout" : "dut2 accept timeout", 32'(acc), 1);
        if (acc) begin
            if (!bad && !w) e.rdata = u ? m0[idx] : m2[idx];
            if (!bad && w) begin
                if (u) m0[idx] = d;
                else   m2[idx] = d;
            end
            e.acc_cyc = cyc;
            if (u) q0.push_back(e);
            else   q2.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic gap(input bit u);
        if (u) begin
            bus0.req = 1'b0; bus0.we = 1'($urandom); bus0.addr = 16'($urandom); bus0.wdata = 16'($urandom);
        end else begin
            bus2.req = 1'b0; bus2.we = 1'($urandom); bus2.addr = 16'($urandom); bus2.wdata = 16'($urandom);
        end
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        bus2.req = 1'b0;
        bus0.req = 1'b0;
        n = 0;
        while ((q2.size() != 0 || q0.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain timeout", 32'(q2.size() + q0.size()), 0);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] rand_addr();
        if ($urandom_range(0, 7) == 0) return 16'($urandom);
        return 16'($urandom_range(0, 63));
    endfunction

    // Monitors: pop the oldest expectation whenever a DUT pulses ack.
    always @(negedge clk) begin
        if (!reset) begin
            last2_r = 16'h0000;
            last2_e = 1'b0;
        end else if (bus2.ack) begin
            if (q2.size() == 0) begin
                check("dut2 spurious ack", 32'(bus2.ack), 0);
            end else begin
                e2 = q2.pop_front();
                check("dut2 rdata", 32'(bus2.rdata), 32'(e2.rdata));
                check("dut2 err", 32'(bus2.err), 32'(e2.err));
                check("dut2 latency", 32'(cyc - e2.acc_cyc), W2 + 1);
                check("dut2 busy at ack", 32'(bus2.busy), 0);
                last2_r = e2.rdata;
                last2_e = e2.err;
            end
        end else begin
            check("dut2 rdata hold", 32'(bus2.rdata), 32'(last2_r));
            check("dut2 err hold", 32'(bus2.err), 32'(last2_e));
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            last0_r = 16'h0000;
            last0_e = 1'b0;
        end else begin
            check("dut0 busy", 32'(bus0.busy), 0);
            if (bus0.ack) begin
                if (q0.size() == 0) begin
                    check("dut0 spurious ack", 32'(bus0.ack), 0);
                end else begin
                    e0 = q0.pop_front();
                    check("dut0 rdata", 32'(bus0.rdata), 32'(e0.rdata));
                    check("dut0 err", 32'(bus0.err), 32'(e0.err));
                    check("dut0 latency", 32'(cyc - e0.acc_cyc), W0 + 1);
                    last0_r = e0.rdata;
                    last0_e = e0.err;
                end
            end else begin
                check("dut0 rdata hold", 32'(bus0.rdata), 32'(last0_r));
                check("dut0 err hold", 32'(bus0.err), 32'(last0_e));
            end
        end
    end

    initial begin
        for (int i = 0; i < int'(D2); i++) m2[i] = 16'h0000;
        for (int i = 0; i < int'(D0); i++) m0[i] = 16'h0000;
        bus2.req = 1'b1; bus2.we = 1'b1; bus2.addr = 16'h0010; bus2.wdata = 16'h5555;
        bus0.req = 1'b1; bus0.we = 1'b1; bus0.addr = 16'h0004; bus0.wdata = 16'h6666;

        // Reset held with req asserted: nothing may be accepted or acknowledged.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset ack", 32'(bus2.ack), 0);
        check("reset err", 32'(bus2.err), 0);
        check("reset rdata", 32'(bus2.rdata), 0);
        check("reset busy", 32'(bus2.busy), 0);
        check("reset dut0 ack", 32'(bus0.ack), 0);
        bus2.req = 1'b0;
        bus0.req = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("idle accept", 32'(bus2.accept), 1);
        check("idle ack", 32'(bus2.ack), 0);
        check("idle rdata", 32'(bus2.rdata), 0);
        check("idle dut0 accept", 32'(bus0.accept), 1);
        @(posedge clk);
        #1;

        // Store then load, then back-to-back loads of preloaded words.
        issue(0, 1'b1, 16'h0010, 16'hBEEF);
        drain();
        issue(0, 1'b0, 16'h0010, 16'h0000);
        drain();
        for (int i = 0; i < 4; i++) issue(0, 1'b1, 16'(2 * i), 16'(i + 1));
        drain();
        for (int i = 0; i < 4; i++) issue(0, 1'b0, 16'(2 * i), 16'hFFFF);
        drain();

        // Faults: misaligned store must not write; out-of-range load.
        issue(0, 1'b1, 16'h0011, 16'h1234);
        issue(0, 1'b0, 16'h0010, 16'h0000);
        issue(0, 1'b0, 16'h0200, 16'h0000);
        drain();

        // Reset during WAIT drops the pending store.
        bus2.req = 1'b1; bus2.we = 1'b1; bus2.addr = 16'h0020; bus2.wdata = 16'hAAAA;
        @(negedge clk);
        check("abort accept", 32'(bus2.accept), 1);
        @(posedge clk);
        #1 bus2.req = 1'b0;
        @(negedge clk);
        check("abort busy in wait", 32'(bus2.busy), 1);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("abort ack", 32'(bus2.ack), 0);
        check("abort busy", 32'(bus2.busy), 0);
        @(posedge clk);
        #1 reset = 1'b1;
        issue(0, 1'b0, 16'h0020, 16'h0000);
        drain();

        // Randomised traffic on both instances.
        for (int i = 0; i < 40; i++) begin
            issue(0, 1'($urandom), rand_addr(), 16'($urandom));
            if ($urandom_range(0, 2) == 0) gap(0);
        end
        drain();
        issue(1, 1'b0, 16'h0010, 16'h0000);
        for (int i = 0; i < 40; i++) begin
            issue(1, 1'($urandom), rand_addr(), 16'($urandom));
            if ($urandom_range(0, 2) == 0) gap(1);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
